// File: rtl/wait_state_responder_pkg.sv
// Shared definitions for the wait-state responder: FSM states, register map
// constants and the I/O window address decode.
package wait_state_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int REG_COUNT = 7;
    localparam int NUM_REGS  = 8;

    // The window is eight registers wide, so only the upper five address bits
    // identify it; the low three bits select the register inside the window.
    function automatic logic addr_match(input logic [7:0] ab, input logic [7:0] base);
        return ab[7:3] == base[7:3];
    endfunction

endpackage

// File: rtl/wait_state_responder_if.sv
// Processor I/O strobes, address and the debug select indicator. The data bus
// and the open-drain wait request are tri-stated, so they stay plain ports.
interface wait_state_responder_if;

    logic       nio;
    logic       nr;
    logic       nw;
    logic [7:0] ab;
    logic       nsel;

    modport master (output nio, nr, nw, ab, input nsel);
    modport slave  (input nio, nr, nw, ab, output nsel);

endinterface

// File: rtl/wait_state_responder_ws_counter.sv
// Loadable down-counter with a zero flag. It times the wait-state phase and
// holds at zero rather than wrapping.
module ws_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wait_state_responder.sv
// I/O-space bus responder: eight-register window, programmable wait states on
// open-drain nWS, scratch registers 0-6 and a completed-access counter at 7.
module wait_state_responder
    import wait_state_defs::*;
#(
    parameter logic [7:0] BASE        = 8'h40,
    parameter int         WAIT_STATES = 2,
    parameter int         CNT_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    wait_state_responder_if.slave   bus,
    inout  wire  [15:0]             db,
    output wire                     nws
);

    localparam logic                 NO_WAIT       = (WAIT_STATES == 0);
    localparam logic [CNT_WIDTH-1:0] LOAD_VAL      = (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;
    localparam logic [2:0]           REG_COUNT_IDX = 3'(REG_COUNT);

    state_t      state;
    logic [15:0] regs [NUM_REGS];
    logic [15:0] count;
    logic [2:0]  index;
    logic        is_read;
    logic        nw_q;
    logic [15:0] hold;
    logic        committed;
    logic        nws_drive;
    logic        db_drive;
    logic [15:0] db_out;
    logic        nsel_q;

    logic        sel;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        commit;
    logic        exit_access;

    assign sel         = ~bus.nio & addr_match(bus.ab, BASE) & (~bus.nr | ~bus.nw);
    assign cnt_load    = (state == IDLE) & sel;
    assign cnt_dec     = (state == WAIT) & ~bus.nio;
    // A write commits on the rising edge of nW; a cycle that also had nR low
    // was captured as a read and never commits.
    assign commit      = (state == ACCESS) & ~is_read & ~nw_q & bus.nw;
    assign exit_access = (bus.nr & bus.nw) | bus.nio;

    ws_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_ws_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (LOAD_VAL),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    function automatic logic [15:0] reg_value(input logic [2:0] idx);
        if (idx == REG_COUNT_IDX) begin
            return count;
        end
        return regs[idx];
    endfunction

    // Bus FSM, register file and access counter; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            index     <= '0;
            is_read   <= 1'b0;
            nw_q      <= 1'b1;
            hold      <= '0;
            committed <= 1'b0;
            nws_drive <= 1'b0;
            db_drive  <= 1'b0;
            db_out    <= '0;
            nsel_q    <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            nw_q <= bus.nw;
            unique case (state)
                IDLE: begin
                    nws_drive <= 1'b0;
                    db_drive  <= 1'b0;
                    nsel_q    <= 1'b1;
                    committed <= 1'b0;
                    if (sel) begin
                        index   <= bus.ab[2:0];
                        is_read <= ~bus.nr;
                        nsel_q  <= 1'b0;
                        if (NO_WAIT) begin
                            state    <= ACCESS;
                            db_drive <= ~bus.nr;
                            db_out   <= reg_value(bus.ab[2:0]);
                        end else begin
                            state     <= WAIT;
                            nws_drive <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.nio) begin
                        state     <= IDLE;
                        nws_drive <= 1'b0;
                        nsel_q    <= 1'b1;
                    end else if (cnt_zero) begin
                        state     <= ACCESS;
                        nws_drive <= 1'b0;
                        db_drive  <= is_read;
                        db_out    <= reg_value(index);
                    end
                end
                ACCESS: begin
                    db_out <= reg_value(index);
                    if (~bus.nw) begin
                        hold <= db;
                    end
                    if (commit) begin
                        committed <= 1'b1;
                        if (index != REG_COUNT_IDX) begin
                            regs[index] <= hold;
                        end
                    end
                    if (exit_access) begin
                        state    <= IDLE;
                        db_drive <= 1'b0;
                        nsel_q   <= 1'b1;
                        if (is_read | committed | commit) begin
                            count <= count + 16'd1;
                        end
                    end else begin
                        db_drive <= is_read & ~bus.nr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nws      = nws_drive ? 1'b0 : 1'bz;
    assign db       = db_drive ? db_out : 16'hzzzz;
    assign bus.nsel = nsel_q;

endmodule

// File: tb/tb_wait_state_responder.sv
// Randomized scoreboard bench for the wait-state responder: one instance with
// two wait states at 8'h40 and one zero-wait instance at 8'h80 share the bus.
module tb_wait_state_responder;

    localparam int WS_A = 2;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        nio      = 1'b1;
    logic        nr       = 1'b1;
    logic        nw       = 1'b1;
    logic [7:0]  ab       = 8'h00;
    logic [15:0] tb_data  = 16'h0000;
    logic        tb_drive = 1'b0;
    wire  [15:0] db;
    wire         nws_a;
    wire         nws_z;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tgt;
        bit          is_read;
        int          waits;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_regs [2][8];
    logic [15:0] model_count [2];
    int          ws_run [2];
    bit          was_present [2];

    wait_state_responder_if bus_a ();
    wait_state_responder_if bus_z ();

    assign bus_a.nio = nio;
    assign bus_a.nr  = nr;
    assign bus_a.nw  = nw;
    assign bus_a.ab  = ab;
    assign bus_z.nio = nio;
    assign bus_z.nr  = nr;
    assign bus_z.nw  = nw;
    assign bus_z.ab  = ab;

    assign db = tb_drive ? tb_data : 16'hzzzz;
    pullup (nws_a);
    pullup (nws_z);
    for (genvar i = 0; i < 16; i++) begin : g_db_pull
        pullup (db[i]);
    end

    always #5 clk = ~clk;

    wait_state_responder #(
        .BASE        (8'h40),
        .WAIT_STATES (WS_A),
        .CNT_WIDTH   (4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a),
        .db  (db),
        .nws (nws_a)
    );

    wait_state_responder #(
        .BASE        (8'h80),
        .WAIT_STATES (0),
        .CNT_WIDTH   (4)
    ) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z),
        .db  (db),
        .nws (nws_z)
    );

    function automatic logic nws_of(input int tgt);
        return (tgt == 0) ? nws_a : nws_z;
    endfunction

    function automatic logic nsel_of(input int tgt);
        return (tgt == 0) ? bus_a.nsel : bus_z.nsel;
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            model_count[t] = 16'h0000;
            for (int r = 0; r < 8; r++) begin
                model_regs[t][r] = 16'h0000;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_present(input int tgt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nsel_of(tgt) == 1'b0 && nws_of(tgt) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete access; the expected response goes to the scoreboard queue
    // and the reference model is updated once the access has completed.
    task automatic apply_stimulus(input int tgt, input logic [7:0] addr, input bit wr,
                                  input logic [15:0] data, input bit late_nio);
        exp_t e;
        bit   ok;
        int   r;
        r         = int'(addr[2:0]);
        e.tgt     = tgt;
        e.is_read = !wr;
        e.waits   = (tgt == 0) ? WS_A : 0;
        e.data    = (r == 7) ? model_count[tgt] : model_regs[tgt][r];
        exp_q.push_back(e);
        @(negedge clk);
        ab  = addr;
        nio = 1'b0;
        if (wr) begin
            nw       = 1'b0;
            tb_data  = data;
            tb_drive = 1'b1;
        end else begin
            nr = 1'b0;
        end
        wait_present(tgt, ok);
        check_output("access_presented", {15'b0, ok}, 16'h0001);
        @(negedge clk);
        nr = 1'b1;
        nw = 1'b1;
        if (!late_nio) begin
            nio = 1'b1;
        end
        @(negedge clk);
        tb_drive = 1'b0;
        nio      = 1'b1;
        if (!wr) begin
            check_output("db_release", db, 16'hFFFF);
        end
        check_output("nsel_idle", {15'b0, nsel_of(tgt)}, 16'h0001);
        if (wr && r != 7) begin
            model_regs[tgt][r] = data;
        end
        model_count[tgt] = model_count[tgt] + 16'd1;
        @(negedge clk);
    endtask

    task automatic apply_miss(input logic [7:0] addr);
        @(negedge clk);
        ab  = addr;
        nio = 1'b0;
        nr  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_output("miss_nws", {15'b0, nws_a}, 16'h0001);
            check_output("miss_nsel", {15'b0, bus_a.nsel}, 16'h0001);
            check_output("miss_db", db, 16'hFFFF);
        end
        nr  = 1'b1;
        nio = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: counts nWS-low clocks per access and pops the scoreboard when
    // an instance enters its data phase.
    always @(negedge clk) begin
        for (int t = 0; t < 2; t++) begin
            logic present;
            exp_t e;
            present = (nsel_of(t) == 1'b0) && (nws_of(t) == 1'b1);
            if (nsel_of(t) == 1'b1) begin
                ws_run[t] = 0;
            end else if (nws_of(t) == 1'b0) begin
                ws_run[t]++;
            end
            if (present && !was_present[t]) begin
                if (exp_q.size() == 0 || exp_q[0].tgt != t) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_access: instance %0d selected, expected no access", t);
                end else begin
                    e = exp_q.pop_front();
                    check_output("wait_states", 16'(ws_run[t]), 16'(e.waits));
                    if (e.is_read) begin
                        check_output("read_data", db, e.data);
                    end
                end
            end
            was_present[t] = present;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        bit   ok;
        model_reset();
        do_reset();
        check_output("reset_nws_a", {15'b0, nws_a}, 16'h0001);
        check_output("reset_nws_z", {15'b0, nws_z}, 16'h0001);
        check_output("reset_nsel_a", {15'b0, bus_a.nsel}, 16'h0001);
        check_output("reset_nsel_z", {15'b0, bus_z.nsel}, 16'h0001);
        check_output("reset_db", db, 16'hFFFF);

        apply_miss(8'h48);
        apply_stimulus(0, 8'h47, 1'b0, 16'h0000, 1'b0);

        apply_stimulus(0, 8'h43, 1'b1, 16'hBEEF, 1'b1);
        apply_stimulus(0, 8'h43, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(0, 8'h42, 1'b0, 16'h0000, 1'b1);

        apply_stimulus(1, 8'h80, 1'b0, 16'h0000, 1'b0);

        // Abort during the wait phase: nIO rises after one wait clock.
        @(negedge clk);
        ab       = 8'h41;
        nio      = 1'b0;
        nw       = 1'b0;
        tb_data  = 16'h1234;
        tb_drive = 1'b1;
        @(negedge clk);
        check_output("abort_nws_low", {15'b0, nws_a}, 16'h0000);
        nio = 1'b1;
        @(negedge clk);
        check_output("abort_nws_release", {15'b0, nws_a}, 16'h0001);
        check_output("abort_nsel", {15'b0, bus_a.nsel}, 16'h0001);
        nw       = 1'b1;
        tb_drive = 1'b0;
        @(negedge clk);
        apply_stimulus(0, 8'h41, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(0, 8'h47, 1'b0, 16'h0000, 1'b0);

        // Reset while a write is held in its data phase.
        e.tgt     = 0;
        e.is_read = 1'b0;
        e.waits   = WS_A;
        e.data    = 16'h0000;
        exp_q.push_back(e);
        @(negedge clk);
        ab       = 8'h45;
        nio      = 1'b0;
        nw       = 1'b0;
        tb_data  = 16'hAAAA;
        tb_drive = 1'b1;
        wait_present(0, ok);
        check_output("rst_write_presented", {15'b0, ok}, 16'h0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_nws", {15'b0, nws_a}, 16'h0001);
        check_output("rst_nsel", {15'b0, bus_a.nsel}, 16'h0001);
        rst      = 1'b0;
        nw       = 1'b1;
        nio      = 1'b1;
        tb_drive = 1'b0;
        model_reset();
        @(negedge clk);
        apply_stimulus(0, 8'h45, 1'b0, 16'h0000, 1'b0);

        // Five completed accesses, then the counter register and its write guard.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 8'h40 + 8'(i), 1'b1, 16'($urandom), 1'b0);
        end
        apply_stimulus(0, 8'h47, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(0, 8'h47, 1'b1, 16'hFFFF, 1'b0);
        apply_stimulus(0, 8'h47, 1'b0, 16'h0000, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = 8'h40 | 8'($urandom_range(0, 7));
            apply_stimulus(0, a, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 8; r++) begin
            apply_stimulus(0, 8'h40 + 8'(r), 1'b0, 16'h0000, 1'b0);
        end

        repeat (3) @(negedge clk);
        check_output("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wait_state_responder.md
Name: wait_state_responder

Overview:
- Bus-side responder for the processor data bus: the I/O-space peripheral at the far end of the nIO/nR/nW/nWS/DB protocol.
- Decodes an 8-register I/O window and requests a programmable number of wait states on open-drain nWS.
- Drives DB on reads and captures DB on writes.
- Registers 0-6 are read/write scratch; register 7 is a read-only completed-access counter. The block serves as a bring-up target and reference responder for bus and wait-state testing.

Parameters:
- BASE, 8'h40: I/O window base. Only BASE[7:3] is compared; the low 3 bits are ignored.
- WAIT_STATES, 2: wait-state clocks requested per access, range 0..15.
- CNT_WIDTH, 4: width of the internal wait counter. Must hold WAIT_STATES.

Ports:
- clk, input, 1: sole clock. All state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- nio, input, 1: I/O space strobe, active low.
- nr, input, 1: read strobe, active low.
- nw, input, 1: write strobe, active low. The write commits on its rising edge.
- ab, input, 8: low I/O address bits.
- db, inout, 16: data bus. Driven only during a selected read; otherwise high-Z.
- nws, output, 1: wait-state request. Open drain: drives 1'b0 or 1'bz, never 1.
- nsel, output, 1: active-low select indicator for debug LEDs. Low in WAIT and ACCESS.

Behaviour:
- Select: sel = ~nio & (ab[7:3] == BASE[7:3]) & (~nr | ~nw). Register index = ab[2:0], captured on leaving IDLE.
- Reset (rst=1 at a clock edge):
  - state=IDLE, regs[0..6]=16'h0000, count register=0, wait counter=0.
  - nws=z, db=z, nsel=1.
  - Reset mid-access aborts immediately; no write commits.
- IDLE:
  - nws=z, db=z.
  - On sel: capture index and direction (read if nr=0).
  - WAIT_STATES=0 -> ACCESS; else -> WAIT with cnt=WAIT_STATES-1.
- WAIT:
  - nws=0 every clock in this state, so exactly WAIT_STATES clocks of nws low.
  - cnt decrements each clock; cnt==0 -> ACCESS.
  - If nio goes high (cycle abort) -> IDLE: nws=z, no write, count unchanged.
- ACCESS:
  - nws=z.
  - Read: db = regs[index] (index 7 returns {zero-pad, count}) while nr=0. The same clock nr is seen high, db returns to z.
  - Write: db is sampled into a holding register every clock while nw=0. On a registered rising edge of nw (nw_q=0, nw=1), the holding register is written to regs[index]. Writes to index 7 are ignored but still counted.
  - Exit to IDLE when nr=1 & nw=1, or nio=1. If this exit follows a read or committed write, count increments, wrapping 16'hFFFF->0.
- Back-to-back accesses: at least one IDLE clock between them. The IDLE clock re-evaluates sel, so a held strobe does not double-count.
- nr and nw low together: treated as a read; no write commits.
- A write whose nw rises in the same clock as nio rises still commits (edge checked before exit).

Decomposition:
- Shared package wait_state_defs: state encodings IDLE/WAIT/ACCESS (2-bit), REG_COUNT=7, NUM_REGS=8.
- Natural sub-module: ws_counter. Loadable down-counter with zero flag, reused by the FSM.
- Register file and tri-state db/nws drivers stay inline.

Test Plan:
- Write then read, WAIT_STATES=2: nio=0, ab=8'h43, nw pulse with db=16'hBEEF.
  - nws low exactly 2 clocks.
  - A later read of 8'h43 returns 16'hBEEF.
  - A read of 8'h42 returns 16'h0000.
- WAIT_STATES=0: read of 8'h40 after reset -> nws never driven low; db=16'h0000 during nr low, z after.
- Address miss: access at 8'h48 -> nws, db and nsel untouched; count stays 0.
- Abort in WAIT: write 16'h1234 to 8'h41, nio raised after 1 wait clock (WAIT_STATES=3) -> nws released next clock; reg1 stays 0; count stays 0.
- Counter and reg 7:
  - 5 completed accesses, then read 8'h47 -> 16'h0005.
  - Write 16'hFFFF to 8'h47 -> the next read of 8'h47 returns 16'h0007.
- Reset mid-write: rst=1 while nw=0 in ACCESS with db=16'hAAAA -> reg unchanged (0); state IDLE; nws=z next clock.
